// File: rtl/scu_tile_scheduler.sv
// scu_tile_scheduler
// Walks one layer's (out_ch, in_ch) space across the POF x PIF SCU array.
// Each SCU row owns ceil(out_ch/POF) output channels and each SCU column
// owns ceil(in_ch/PIF) input channels; one local (o, i) step is broadcast
// per issue handshake together with a per-SCU enable mask.
// Optional build macro: SCU_SCHED_PERF_EN adds the stall_cycles counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; rejects zero channel counts with cfg_err
// SETUP | serial dividers produce rows-per-group and cols-per-group
// RUN   | issuing (o, i) steps, i inner loop, o outer loop

module scu_tile_scheduler #(
    parameter int POF       = 4,
    parameter int PIF       = 12,
    parameter int IDX_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IDX_WIDTH-1:0] cfg_out_ch,
    input  logic [IDX_WIDTH-1:0] cfg_in_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [IDX_WIDTH-1:0] issue_o,
    output logic [IDX_WIDTH-1:0] issue_i,
    output logic [POF*PIF-1:0]   issue_mask,
    output logic                 issue_last
`ifdef SCU_SCHED_PERF_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int W  = IDX_WIDTH;
    localparam int PW = 2 * IDX_WIDTH;
    localparam int CW = $clog2(IDX_WIDTH + 1);
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          start_ok;
    logic          start_bad;
    logic          hs;
    logic          last_step;
    logic [W-1:0]  out_ch_q, in_ch_q;
    // Shift registers: numerator bits shift out at the top, quotient bits
    // shift in at the bottom; after SETUP they hold opr / ipc.
    logic [W-1:0]  opr_q, ipc_q;
    logic [W-1:0]  orem_q, irem_q;
    logic [CW-1:0] setup_cnt_q;
    logic [W-1:0]  o_q, i_q;
    logic          done_q, cfg_err_q;
    logic [W:0]    onum, inum;
    logic [W:0]    otrial, itrial;
    logic          oge, ige;
    logic [POF-1:0] row_valid;
    logic [PIF-1:0] col_valid;

    // Rounded-up numerators; the extra bit keeps ch + D - 1 from wrapping.
    assign onum = {1'b0, cfg_out_ch} + (W+1)'(POF - 1);
    assign inum = {1'b0, cfg_in_ch} + (W+1)'(PIF - 1);

    // The quotient always fits in W bits, so the numerator's top bit seeds
    // the remainder and only W restoring steps are needed.
    assign otrial = {orem_q, opr_q[W-1]};
    assign itrial = {irem_q, ipc_q[W-1]};
    assign oge    = (otrial >= (W+1)'(POF));
    assign ige    = (itrial >= (W+1)'(PIF));

    assign last_step = (o_q == opr_q - ONE) && (i_q == ipc_q - ONE);
    assign hs        = issue_valid && issue_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        issue_valid = 1'b0;
        start_ok    = 1'b0;
        start_bad   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_out_ch == '0 || cfg_in_ch == '0) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = SETUP;
                    end
                end
            end
            SETUP: begin
                busy = 1'b1;
                if (setup_cnt_q == '0) state_d = RUN;
            end
            RUN: begin
                busy        = 1'b1;
                issue_valid = 1'b1;
                if (issue_ready && last_step) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Config latch and the two serial restoring dividers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ch_q    <= '0;
            in_ch_q     <= '0;
            opr_q       <= '0;
            ipc_q       <= '0;
            orem_q      <= '0;
            irem_q      <= '0;
            setup_cnt_q <= '0;
        end else if (start_ok) begin
            out_ch_q    <= cfg_out_ch;
            in_ch_q     <= cfg_in_ch;
            opr_q       <= onum[W-1:0];
            ipc_q       <= inum[W-1:0];
            orem_q      <= {{(W-1){1'b0}}, onum[W]};
            irem_q      <= {{(W-1){1'b0}}, inum[W]};
            setup_cnt_q <= CW'(W - 1);
        end else if (state_q == SETUP) begin
            opr_q       <= {opr_q[W-2:0], oge};
            ipc_q       <= {ipc_q[W-2:0], ige};
            orem_q      <= oge ? W'(otrial - (W+1)'(POF)) : otrial[W-1:0];
            irem_q      <= ige ? W'(itrial - (W+1)'(PIF)) : itrial[W-1:0];
            setup_cnt_q <= setup_cnt_q - CW'(1);
        end
    end

    // Step counters; advance only on a handshake so the payload holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
            i_q <= '0;
        end else if (start_ok) begin
            o_q <= '0;
            i_q <= '0;
        end else if (hs) begin
            if (last_step) begin
                o_q <= '0;
                i_q <= '0;
            end else if (i_q == ipc_q - ONE) begin
                i_q <= '0;
                o_q <= o_q + ONE;
            end else begin
                i_q <= i_q + ONE;
            end
        end
    end

    // Single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= hs && last_step;
            cfg_err_q <= start_bad;
        end
    end

    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign issue_o    = o_q;
    assign issue_i    = i_q;
    assign issue_last = issue_valid && last_step;

    // Channel tail masking: a row/column is live while its channel exists.
    for (genvar r = 0; r < POF; r++) begin : g_row
        assign row_valid[r] = (PW'(r) * PW'(opr_q) + PW'(o_q)) < PW'(out_ch_q);
    end

    for (genvar c = 0; c < PIF; c++) begin : g_col
        assign col_valid[c] = (PW'(c) * PW'(ipc_q) + PW'(i_q)) < PW'(in_ch_q);
    end

    for (genvar r = 0; r < POF; r++) begin : g_mr
        for (genvar c = 0; c < PIF; c++) begin : g_mc
            assign issue_mask[r*PIF+c] = issue_valid && row_valid[r] && col_valid[c];
        end
    end

`ifdef SCU_SCHED_PERF_EN
    // Saturating backpressure counter, cleared per layer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if (issue_valid && !issue_ready && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scu_tile_scheduler.sv
// tb_scu_tile_scheduler
// Directed and randomized layers checked against a loop-level model of the
// channel partitioning. Build with SCU_SCHED_PERF_EN to also check stalls.

module tb_scu_tile_scheduler;

    localparam int POF = 4;
    localparam int PIF = 12;
    localparam int W   = 16;
    localparam int NB  = POF * PIF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  cfg_out_ch, cfg_in_ch;
    logic          busy, done, cfg_err;
    logic          issue_valid, issue_ready;
    logic [W-1:0]  issue_o, issue_i;
    logic [NB-1:0] issue_mask;
    logic          issue_last;
`ifdef SCU_SCHED_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int            exp_o[$];
    int            exp_i[$];
    logic [NB-1:0] exp_mask[$];
    logic          exp_last[$];

    scu_tile_scheduler #(.POF(POF), .PIF(PIF), .IDX_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_out_ch  (cfg_out_ch),
        .cfg_in_ch   (cfg_in_ch),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_o     (issue_o),
        .issue_i     (issue_i),
        .issue_mask  (issue_mask),
        .issue_last  (issue_last)
`ifdef SCU_SCHED_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Row r serves output channel r*opr+o, column c serves input channel
    // c*ipc+i; an SCU is enabled when both channels exist.
    task automatic build_model(input int oc, input int ic);
        int opr, ipc;
        logic [NB-1:0] m;
        opr = (oc + POF - 1) / POF;
        ipc = (ic + PIF - 1) / PIF;
        exp_o.delete();
        exp_i.delete();
        exp_mask.delete();
        exp_last.delete();
        for (int o = 0; o < opr; o++) begin
            for (int i = 0; i < ipc; i++) begin
                m = '0;
                for (int r = 0; r < POF; r++)
                    for (int c = 0; c < PIF; c++)
                        if (r * opr + o < oc && c * ipc + i < ic) m[r*PIF+c] = 1'b1;
                exp_o.push_back(o);
                exp_i.push_back(i);
                exp_mask.push_back(m);
                exp_last.push_back(o == opr - 1 && i == ipc - 1);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, issue_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_o"}, issue_o, 0);
        chk({tag, "_i"}, issue_i, 0);
        chk({tag, "_mask"}, issue_mask, 0);
        chk({tag, "_last"}, issue_last, 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall on step 1,
    // 3: always ready plus a start pulse during SETUP that must be ignored.
    // Returns at the sample point of the done cycle.
    task automatic run_layer(input int oc, input int ic, input int mode);
        int   cnt, idx, n, stall_left, exp_stalls, budget;
        logic rdy;
        build_model(oc, ic);
        n = exp_o.size();
        cfg_out_ch = W'(oc);
        cfg_in_ch  = W'(ic);
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 1;
        while (!issue_valid && cnt < 40) begin
            chk("setup_busy", busy, 1);
            chk("setup_done", done, 0);
            if (mode == 3 && cnt == 3) begin
                start = 1'b1;
                cfg_out_ch = W'(1);
                cfg_in_ch  = W'(1);
            end else begin
                start = 1'b0;
            end
            tick();
            cnt++;
        end
        start = 1'b0;
        chk("first_valid_latency", cnt, 17);
        idx = 0;
        stall_left = 5;
        exp_stalls = 0;
        budget = 0;
        while (idx < n && budget < 8 * n + 64) begin
            chk("run_valid", issue_valid, 1);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk($sformatf("step%0d_o", idx), issue_o, exp_o[idx]);
            chk($sformatf("step%0d_i", idx), issue_i, exp_i[idx]);
            chk($sformatf("step%0d_mask", idx), issue_mask, exp_mask[idx]);
            chk($sformatf("step%0d_last", idx), issue_last, exp_last[idx]);
            case (mode)
                1: rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    rdy = !(idx == 1 && stall_left > 0);
                    if (!rdy) stall_left--;
                end
                default: rdy = 1'b1;
            endcase
            if (!rdy) exp_stalls++;
            issue_ready = rdy;
            tick();
            if (rdy) idx++;
            budget++;
        end
        issue_ready = 1'b0;
        chk("all_steps_issued", idx, n);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", issue_valid, 0);
        chk("done_cfg_err", cfg_err, 0);
`ifdef SCU_SCHED_PERF_EN
        chk("stall_cycles", stall_cycles, exp_stalls);
`endif
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        start = 1'b0;
        issue_ready = 1'b0;
        cfg_out_ch = '0;
        cfg_in_ch = '0;
        repeat (3) tick();
        check_quiet("reset");
`ifdef SCU_SCHED_PERF_EN
        chk("reset_stall", stall_cycles, 0);
`endif
        rst = 1'b0;
        tick();
        check_quiet("idle");

        // Default layer, then back-to-back starts issued in the done cycle.
        run_layer(8, 24, 0);
        run_layer(5, 13, 0);
        run_layer(1, 1, 0);
        tick();
        chk("done_one_cycle", done, 0);

        run_layer(8, 24, 2);
        tick();
        run_layer(8, 24, 3);
        tick();

        // Zero counts are rejected.
        cfg_out_ch = W'(0);
        cfg_in_ch  = W'(12);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        chk("cfg_err_done", done, 0);
        chk("cfg_err_valid", issue_valid, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_quiet("after_cfg_err");
        end
        cfg_out_ch = W'(12);
        cfg_in_ch  = W'(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfg_err_in_zero", cfg_err, 1);
        tick();
        chk("cfg_err_one_cycle", cfg_err, 0);

        // Reset on the second RUN handshake.
        cfg_out_ch = W'(8);
        cfg_in_ch  = W'(24);
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 1;
        while (!issue_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("rst_run_latency", cnt, 17);
        issue_ready = 1'b1;
        tick();
        chk("rst_step1_i", issue_i, 1);
        rst = 1'b1;
        tick();
        check_quiet("mid_run_rst");
`ifdef SCU_SCHED_PERF_EN
        chk("mid_run_rst_stall", stall_cycles, 0);
`endif
        rst = 1'b0;
        issue_ready = 1'b0;
        tick();
        check_quiet("post_rst");
        run_layer(8, 24, 0);
        tick();

        // Randomized layers with random backpressure.
        for (int k = 0; k < 8; k++) begin
            run_layer(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), 1);
            if ($urandom_range(0, 1) == 0) tick();
        end

        // Wide counts exercise the extra numerator bit and the column tail.
        tick();
        run_layer(65535, 12, 0);
        tick();
        run_layer(4, 65535, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scu_tile_scheduler.md
Name: scu_tile_scheduler

Overview:
- Sequences the POFxPIF SCU array over one layer's (out_ch, in_ch) space.
- Uses the same channel-to-SCU partitioning as the SCU mapper:
  - each SCU row owns ceil(out_ch/POF) consecutive output channels;
  - each SCU column owns ceil(in_ch/PIF) consecutive input channels.
- Broadcasts one (o, i) local-offset step per handshake, with a per-SCU enable mask so SCUs past the channel tail stay idle.
- Sits between the layer controller (start/config) and the SCU array issue bus.

Parameters:
- POF, 4, SCU rows.
- PIF, 12, SCU columns.
- IDX_WIDTH, 16, channel count/index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle layer start; honoured only in IDLE.
- cfg_out_ch  in  IDX_WIDTH  output channel count, sampled on accepted start.
- cfg_in_ch  in  IDX_WIDTH  input channel count, sampled on accepted start.
- busy  out  1  high in SETUP and RUN.
- done  out  1  one-cycle pulse after final issue handshake.
- cfg_err  out  1  one-cycle pulse when start is rejected for a zero count.
- issue_valid  out  1  issue payload valid.
- issue_ready  in  1  SCU array accepts the payload.
- issue_o  out  IDX_WIDTH  local output-channel offset within the row group.
- issue_i  out  IDX_WIDTH  local input-channel offset within the column group.
- issue_mask  out  POF*PIF  SCU enables; bit r*PIF+c corresponds to SCU (r,c).
- issue_last  out  1  marks the final step of the layer.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state IDLE; busy, done, cfg_err, issue_valid and issue_last 0; issue_o, issue_i and issue_mask 0; internal counters and latches 0.
- rst overrides everything, including mid-SETUP or mid-RUN: next cycle is IDLE with reset values. Any in-flight payload is dropped and no done is produced.
- FSM states: IDLE, SETUP, RUN.
- IDLE:
  - On start with either cfg count equal to 0: cfg_err=1 for the next cycle, stay in IDLE, no done.
  - Otherwise: latch the counts and go to SETUP.
  - start while busy is ignored; the latched config is unchanged.
- SETUP:
  - Two parallel restoring dividers compute opr=ceil(out_ch/POF) and ipc=ceil(in_ch/PIF).
  - Numerators are (ch+POF-1) and (ch+PIF-1), evaluated at IDX_WIDTH+1 bits so nothing overflows.
  - Lasts exactly IDX_WIDTH cycles, then goes to RUN with o=0, i=0.
  - No combinational dividers anywhere in the block.
- RUN:
  - issue_valid=1 from the first RUN cycle. It is asserted IDX_WIDTH+1 cycles after the cycle start was sampled.
  - Payload (issue_o, issue_i, issue_mask, issue_last) is held stable while issue_valid && !issue_ready.
  - issue_valid never drops without a handshake.
- Step order: i is the inner loop (0..ipc-1), o the outer loop (0..opr-1). Total steps = opr*ipc.
- Mask: bit(r,c) = (r*opr + o < out_ch) && (c*ipc + i < in_ch).
  - Computed as row_valid[POF] and col_valid[PIF] vectors, then AND-ed.
  - Products are evaluated at 2*IDX_WIDTH bits.
  - The mask is never all-zero.
- issue_last=1 iff o==opr-1 && i==ipc-1.
- On handshake with issue_last:
  - next cycle: state IDLE, done=1 for one cycle, busy=0, issue_valid=0;
  - a start in that done cycle is accepted normally.
- done and cfg_err are never asserted together.
- busy=1 exactly while the state is SETUP or RUN.

Optional Feature:
- Macro: SCU_SCHED_PERF_EN.
- Defined: adds output stall_cycles (32 bits).
  - Counts cycles with issue_valid && !issue_ready.
  - Cleared to 0 on an accepted start and on rst.
  - Saturates at 0xFFFFFFFF.
  - Holds its value in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Defaults, out_ch=8, in_ch=24, issue_ready=1:
  - first issue_valid 17 cycles after start;
  - 4 issues, (o,i) = (0,0),(0,1),(1,0),(1,1);
  - every mask all-ones (48 bits); issue_last only on (1,1);
  - done pulse the next cycle.
- out_ch=5, in_ch=13 (opr=2, ipc=2):
  - step (0,0) mask: rows 0-2 x cols 0-6;
  - step (0,1): rows 0-2 x cols 0-5;
  - step (1,0): rows 0-1 x cols 0-6;
  - step (1,1): rows 0-1 x cols 0-5;
  - row 3 is always 0.
- out_ch=1, in_ch=1: single issue (0,0), mask=bit0 only, issue_last=1, then done.
- Backpressure, out_ch=8, in_ch=24: hold issue_ready=0 for 5 cycles on step (0,1).
  - Payload stays constant and valid remains high.
  - With SCU_SCHED_PERF_EN defined, stall_cycles=5 at done.
- start with out_ch=0, in_ch=12:
  - cfg_err pulse next cycle; busy stays 0; no issue_valid; no done.
  - A second start pulsed while busy is ignored.
- Assert rst on the 2nd RUN handshake cycle:
  - next cycle all outputs at reset values; no done;
  - a subsequent start runs the full sequence normally.
